// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing controller for the MIPS multiply family
// (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) in front of a combinational signed
// 32x32 multiplier core. Operands are latched and held on the core for
// CALC_CYCLES cycles. The signed product is corrected for unsigned operands
// and then combined with {HI,LO}. The result goes out as a single write strobe.
// busy stalls the pipeline for the whole operation.

module mult_ctrl #(
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        core_en,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [63:0] core_product,
  input  logic [63:0] hilo_in,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_out,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_CORR = 3'd2,
    ST_ACC  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Counter reload value: number of extra MUL cycles after the first one.
  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  // Opcodes 110 and 111 are not part of the multiply family.
  function automatic logic op_legal(input logic [2:0] o);
    return (o[2:1] != 2'b11);
  endfunction

  // The core only forms signed products. For unsigned operands, add the
  // weight of each operand's sign bit back in. Only the low 32 bits of the
  // adjustment survive the shift into the upper word, modulo 2^64.
  function automatic logic [63:0] unsigned_fix(input logic [63:0] p,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] adj;
    adj = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
    return p + {adj, 32'd0};
  endfunction

  // Combine the product with the current {HI,LO}. op[2:1] selects the mode:
  // plain multiply, accumulate or subtract. All arithmetic wraps.
  function automatic logic [63:0] accumulate(input logic [2:0]  o,
                                             input logic [63:0] hi,
                                             input logic [63:0] p);
    logic [63:0] r;
    case (o[2:1])
      2'b01:   r = hi + p;
      2'b10:   r = hi - p;
      default: r = p;
    endcase
    return r;
  endfunction

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic [63:0] prod_r;
  logic [63:0] res_r;
  logic [63:0] last_r;

  logic accept_s;
  logic sample_s;
  logic corr_s;
  logic acc_s;
  logic wb_s;

  // State register. Reset lands in IDLE from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and per-state datapath strobes. flush overrides every
  // transition and suppresses the write-back.
  always_comb begin
    state_nx = state;
    accept_s = 1'b0;
    sample_s = 1'b0;
    corr_s   = 1'b0;
    acc_s    = 1'b0;
    wb_s     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!flush && start && op_legal(op)) begin
          accept_s = 1'b1;
          state_nx = ST_MUL;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else if (cnt == 4'd0) begin
          sample_s = 1'b1;
          state_nx = ST_CORR;
        end else begin
          state_nx = ST_MUL;
        end
      end
      ST_CORR: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else begin
          corr_s   = 1'b1;
          state_nx = ST_ACC;
        end
      end
      ST_ACC: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else begin
          acc_s    = 1'b1;
          state_nx = ST_WB;
        end
      end
      ST_WB: begin
        if (flush) begin
          wb_s = 1'b0;
        end else begin
          wb_s = 1'b1;
        end
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Operand and opcode latches. They are loaded only when a request is
  // accepted, so later start pulses cannot disturb a running operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= 32'd0;
      b_r  <= 32'd0;
      op_r <= 3'd0;
    end else if (accept_s) begin
      a_r  <= rs_val;
      b_r  <= rt_val;
      op_r <= op;
    end else begin
      a_r  <= a_r;
      b_r  <= b_r;
      op_r <= op_r;
    end
  end

  // MUL-phase down-counter. The product is sampled when it reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept_s) begin
      cnt <= CNT_LOAD;
    end else if (state == ST_MUL && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Product register. It captures the core output, then applies the
  // unsigned correction in CORR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= 64'd0;
    end else if (sample_s) begin
      prod_r <= core_product;
    end else if (corr_s && op_r[0]) begin
      prod_r <= unsigned_fix(prod_r, a_r, b_r);
    end else begin
      prod_r <= prod_r;
    end
  end

  // Result register. It is formed in ACC, while hilo_in is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_r <= 64'd0;
    end else if (acc_s) begin
      res_r <= accumulate(op_r, hilo_in, prod_r);
    end else begin
      res_r <= res_r;
    end
  end

  // Last committed result. It updates only on an unflushed write, so a
  // discarded operation leaves the visible {HI,LO} value untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 64'd0;
    end else if (wb_s) begin
      last_r <= res_r;
    end else begin
      last_r <= last_r;
    end
  end

  // Output decode. Everything comes from state or from registers, apart from
  // the flush gating on the write strobe.
  always_comb begin
    busy     = 1'b0;
    core_en  = 1'b0;
    hilo_we  = 1'b0;
    done     = 1'b0;
    hilo_out = last_r;
    core_a   = a_r;
    core_b   = b_r;
    if (state != ST_IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
    if (state == ST_MUL) begin
      core_en = 1'b1;
    end else begin
      core_en = 1'b0;
    end
    if (state == ST_WB) begin
      hilo_out = res_r;
    end else begin
      hilo_out = last_r;
    end
    hilo_we = wb_s;
    done    = wb_s;
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: directed test-plan cases, flush and
// reset scenarios, and randomized operations checked against an arithmetic
// reference model.

module tb_mult_ctrl;

  localparam int CC  = 1;
  localparam int LAT = CC + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        core_en;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [63:0] core_product;
  logic [63:0] hilo_in = 64'd0;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_out;
  logic        done;

  logic [63:0] sext_a;
  logic [63:0] sext_b;

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] prev_hilo = 64'd0;

  mult_ctrl #(.CALC_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .core_en(core_en), .core_a(core_a),
    .core_b(core_b), .core_product(core_product), .hilo_in(hilo_in),
    .busy(busy), .hilo_we(hilo_we), .hilo_out(hilo_out), .done(done)
  );

  // Signed core model: a 64-bit product of the sign-extended operands.
  assign sext_a       = {{32{core_a[31]}}, core_a};
  assign sext_b       = {{32{core_b[31]}}, core_b};
  assign core_product = sext_a * sext_b;

  always #5 clk = ~clk;

  // Reference: exact signed or unsigned product, then the HI/LO combination.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hi);
    logic [63:0] p;
    if (o[0]) p = {32'd0, a} * {32'd0, b};
    else      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    if (o == 3'd2 || o == 3'd3)      return hi + p;
    else if (o == 3'd4 || o == 3'd5) return hi - p;
    else                             return p;
  endfunction

  // Issue one operation in the current cycle (cycle 0) and check every cycle
  // up to and including the idle cycle after the write. If restart is set,
  // start is re-pulsed with other operands in cycles 1-3.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hi, input bit restart, input string name);
    logic [63:0] exp_res;
    logic        exp_en;
    logic        exp_we;
    exp_res = ref_result(o, a, b, hi);
    op = o; rs_val = a; rt_val = b; hilo_in = hi; start = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (restart && k <= 3) begin
        start = 1'b1; op = 3'($urandom_range(0, 5));
        rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
      #1;
      exp_en = (k <= CC);
      exp_we = (k == LAT);
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy k=%0d got %b want 1", name, k, busy); end
      vectors++;
      if (core_en !== exp_en) begin errors++; $display("FAIL %s core_en k=%0d got %b want %b", name, k, core_en, exp_en); end
      vectors++;
      if (hilo_we !== exp_we) begin errors++; $display("FAIL %s hilo_we k=%0d got %b want %b", name, k, hilo_we, exp_we); end
      vectors++;
      if (done !== exp_we) begin errors++; $display("FAIL %s done k=%0d got %b want %b", name, k, done, exp_we); end
      if (k == LAT) begin
        vectors++;
        if (hilo_out !== exp_res) begin errors++; $display("FAIL %s result got %h want %h", name, hilo_out, exp_res); end
      end else begin
        vectors++;
        if (hilo_out !== prev_hilo) begin errors++; $display("FAIL %s hold k=%0d got %h want %h", name, k, hilo_out, prev_hilo); end
      end
    end
    prev_hilo = exp_res;
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      errors++; $display("FAIL %s post_idle got busy=%b we=%b want 0 0", name, busy, hilo_we);
    end
    vectors++;
    if (hilo_out !== prev_hilo) begin errors++; $display("FAIL %s post_hold got %h want %h", name, hilo_out, prev_hilo); end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, hilo_we, done, core_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {busy, hilo_we, done, core_en});
    end
    vectors++;
    if ({hilo_out, core_a, core_b} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", hilo_out, core_a, core_b);
    end
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    prev_hilo = 64'd0;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'hFFFFFFFE, 32'h00000003, 64'd0, 1'b0, "mult_neg");
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, "multu_max");
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0, "mult_m1");
    run_op(3'd2, 32'd5, 32'hFFFFFFFF, 64'h10, 1'b0, "madd");
    run_op(3'd5, 32'd1, 32'd1, 64'd0, 1'b0, "msubu");
    vectors++;
    if (prev_hilo !== 64'hFFFFFFFF_FFFFFFFF) begin
      errors++; $display("FAIL msubu_model got %h want ffffffffffffffff", prev_hilo);
    end
  endtask

  task automatic test_flush();
    // flush in cycle 1 of a MULT, then a fresh MULTU from cycle 2
    op = 3'd0; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b1; #1;
    vectors++;
    if (hilo_we !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_c1 got we=%b done=%b want 0 0", hilo_we, done);
    end
    @(negedge clk); flush = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    vectors++;
    if (hilo_out !== prev_hilo) begin errors++; $display("FAIL flush_hold got %h want %h", hilo_out, prev_hilo); end
    run_op(3'd1, 32'd2, 32'd3, 64'd0, 1'b0, "after_flush");
    // flush in the WB cycle suppresses the write
    op = 3'd2; rs_val = 32'd100; rt_val = 32'd100; hilo_in = 64'd1; start = 1'b1;
    for (int k = 1; k < LAT; k++) begin @(negedge clk); start = 1'b0; end
    @(negedge clk); flush = 1'b1; #1;
    vectors++;
    if (hilo_we !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_wb got we=%b done=%b want 0 0", hilo_we, done);
    end
    @(negedge clk); flush = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0 || hilo_out !== prev_hilo) begin
      errors++; $display("FAIL flush_wb_hold got busy=%b out=%h want 0 %h", busy, hilo_out, prev_hilo);
    end
    // flush and start together in IDLE: no start
    op = 3'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start got busy=%b want 0", busy); end
  endtask

  task automatic test_ignore();
    run_op(3'd3, 32'h80000001, 32'h12345678, 64'h1111_2222_3333_4444, 1'b1, "restart_ignored");
    op = 3'd6; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0 || core_en !== 1'b0) begin
      errors++; $display("FAIL illegal_op got busy=%b en=%b want 0 0", busy, core_en);
    end
    op = 3'd7; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    vectors++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      errors++; $display("FAIL illegal_op7 got busy=%b we=%b want 0 0", busy, hilo_we);
    end
  endtask

  task automatic test_async_reset();
    op = 3'd0; rs_val = 32'd11; rt_val = 32'd13; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    vectors++;
    if (busy !== 1'b1 || core_en !== 1'b1) begin
      errors++; $display("FAIL arst_pre got busy=%b en=%b want 1 1", busy, core_en);
    end
    vectors++;
    if (hilo_out === 64'd0) begin errors++; $display("FAIL arst_setup got %h want nonzero", hilo_out); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, hilo_we, core_en, done} !== 4'b0000 || hilo_out !== 64'd0) begin
      errors++; $display("FAIL arst_async got ctrl=%b out=%h want 0000 0",
                         {busy, hilo_we, core_en, done}, hilo_out);
    end
    @(negedge clk); #1 rst = 1'b0;
    prev_hilo = 64'd0;
    run_op(3'd1, 32'hDEADBEEF, 32'h00000002, 64'd0, 1'b0, "after_arst");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hi;
    int          gap;
    for (int i = 0; i < 40; i++) begin
      o   = 3'($urandom_range(0, 5));
      a   = $urandom;
      b   = $urandom;
      if (i % 5 == 0) a = 32'h80000000;
      hi  = {$urandom, $urandom};
      run_op(o, a, b, hi, 1'b0, "random");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd4, 32'd6, 32'd7, 64'd100, 1'b0, "b2b_msub");
    run_op(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'd0, 1'b0, "b2b_mult");
    run_op(3'd2, 32'h80000000, 32'h80000000, 64'hFFFFFFFF_FFFFFFFF, 1'b0, "b2b_madd");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
